// File: rtl/sum_pkg.sv
// Shared types and constants for the status-update scheduler.
// Holds the FSM state encoding, address stride and index-width helper.
package sum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sum_state_e;

  localparam int unsigned SU_ADDR_STRIDE = 8;

  // Width of a requester index for 2*flows requesters, never below one bit.
  function automatic int unsigned idx_width(input int unsigned flows);
    int unsigned w;
    w = $clog2(2 * flows);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sum_rr_arbiter.sv
// Combinational N-way round-robin pick: first set bit of elig_i at or
// after ptr_i, wrapping modulo N.
module sum_rr_arbiter
  import sum_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand_s;

  // Scan from the pointer; the first eligible candidate wins.
  always_comb begin
    vld_o  = 1'b0;
    idx_o  = '0;
    cand_s = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = IW'((32'(ptr_i) + 32'(k)) % N);
      if (!vld_o && elig_i[cand_s]) begin
        vld_o = 1'b1;
        idx_o = cand_s;
      end else begin
        vld_o = vld_o;
      end
    end
  end

endmodule

// File: rtl/sum_update_sched.sv
// Status-update scheduler: one coalescing entry per RX/TX requester,
// flushed on flags or timeout through a single shared DMA write path.
module sum_update_sched
  import sum_pkg::*;
#(
  parameter int unsigned FLOWS         = 2,
  parameter int unsigned SU_DATA_WIDTH = 32,
  parameter logic [63:0] BASE_ADDR     = 64'h0,
  parameter int unsigned TIMEOUT_WIDTH = 10
) (
  input  logic                               CLK,
  input  logic                               RESET_N,
  input  logic [2*FLOWS-1:0]                 SU_DVLD,
  input  logic [2*FLOWS*SU_DATA_WIDTH-1:0]   SU_DATA,
  input  logic [2*FLOWS-1:0]                 SU_INTF,
  input  logic [2*FLOWS-1:0]                 SU_LFF,
  input  logic [TIMEOUT_WIDTH-1:0]           TIMEOUT,
  input  logic                               ENABLE,
  output logic                               DMA_REQ,
  output logic [63:0]                        DMA_ADDR,
  output logic [SU_DATA_WIDTH-1:0]           DMA_DATA,
  input  logic                               DMA_ACK,
  input  logic                               DMA_DONE,
  output logic [2*FLOWS-1:0]                 INTERRUPT,
  output logic                               BUSY
);

  localparam int unsigned N  = 2 * FLOWS;
  localparam int unsigned IW = idx_width(FLOWS);
  localparam int unsigned TW = TIMEOUT_WIDTH;

  logic [N-1:0]             pend_q;
  logic [N-1:0]             intf_q;
  logic [N-1:0]             lff_q;
  logic [TW-1:0]            cnt_q  [N];
  logic [SU_DATA_WIDTH-1:0] data_q [N];

  sum_state_e               state_q;
  logic [IW-1:0]            ptr_q;
  logic [IW-1:0]            gnt_idx_q;
  logic                     gnt_intf_q;
  logic                     req_q;
  logic [63:0]              addr_q;
  logic [SU_DATA_WIDTH-1:0] dout_q;
  logic [N-1:0]             irq_q;
  logic                     busy_q;

  logic [N-1:0]             elig_s;
  logic                     arb_vld_s;
  logic [IW-1:0]            arb_idx_s;
  logic                     grant_s;

  // An entry becomes eligible on either flag or once its age reaches TIMEOUT.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < N; i++) begin
      elig_s[i] = pend_q[i] & (intf_q[i] | lff_q[i] | (cnt_q[i] >= TIMEOUT));
    end
  end

  sum_rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .elig_i (elig_s),
    .ptr_i  (ptr_q),
    .vld_o  (arb_vld_s),
    .idx_o  (arb_idx_s)
  );

  assign grant_s = (state_q == ST_IDLE) && ENABLE && arb_vld_s;

  // Entry store: capture, coalesce, age and clear-on-grant per requester.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_q <= '0;
      intf_q <= '0;
      lff_q  <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (SU_DVLD[i]) begin
          data_q[i] <= SU_DATA[i*SU_DATA_WIDTH +: SU_DATA_WIDTH];
          pend_q[i] <= 1'b1;
          // A grant in the same cycle takes the old contents, so restart fresh.
          if (!pend_q[i] || (grant_s && (arb_idx_s == IW'(i)))) begin
            intf_q[i] <= SU_INTF[i];
            lff_q[i]  <= SU_LFF[i];
            cnt_q[i]  <= '0;
          end else begin
            intf_q[i] <= intf_q[i] | SU_INTF[i];
            lff_q[i]  <= lff_q[i] | SU_LFF[i];
            cnt_q[i]  <= (cnt_q[i] == {TW{1'b1}}) ? cnt_q[i] : cnt_q[i] + TW'(1);
          end
        end else if (grant_s && (arb_idx_s == IW'(i))) begin
          pend_q[i] <= 1'b0;
          intf_q[i] <= 1'b0;
          lff_q[i]  <= 1'b0;
          cnt_q[i]  <= '0;
        end else if (pend_q[i]) begin
          cnt_q[i]  <= (cnt_q[i] == {TW{1'b1}}) ? cnt_q[i] : cnt_q[i] + TW'(1);
        end else begin
          cnt_q[i]  <= cnt_q[i];
        end
      end
    end
  end

  // Transfer FSM with registered DMA, interrupt and busy outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_intf_q <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= 64'h0;
      dout_q     <= '0;
      irq_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      irq_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_s) begin
            state_q    <= ST_REQ;
            busy_q     <= 1'b1;
            req_q      <= 1'b1;
            addr_q     <= BASE_ADDR + (64'(arb_idx_s) * 64'(SU_ADDR_STRIDE));
            dout_q     <= data_q[arb_idx_s];
            gnt_idx_q  <= arb_idx_s;
            gnt_intf_q <= intf_q[arb_idx_s];
            if (32'(arb_idx_s) == N - 1) begin
              ptr_q <= '0;
            end else begin
              ptr_q <= arb_idx_s + IW'(1);
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (DMA_ACK) begin
            req_q <= 1'b0;
            // ACK and DONE together complete the transfer outright.
            if (DMA_DONE) begin
              state_q           <= ST_IDLE;
              busy_q            <= 1'b0;
              irq_q[gnt_idx_q]  <= gnt_intf_q;
            end else begin
              state_q <= ST_WAIT_DONE;
            end
          end else begin
            state_q <= ST_REQ;
          end
        end
        ST_WAIT_DONE: begin
          if (DMA_DONE) begin
            state_q          <= ST_IDLE;
            busy_q           <= 1'b0;
            irq_q[gnt_idx_q] <= gnt_intf_q;
          end else begin
            state_q <= ST_WAIT_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DMA_REQ   = req_q;
  assign DMA_ADDR  = addr_q;
  assign DMA_DATA  = dout_q;
  assign INTERRUPT = irq_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_sum_update_sched.sv
// Scoreboard bench for sum_update_sched: stimulus pushes expected writes and
// interrupts, a negedge monitor pops and compares what the DUT presents.
module tb_sum_update_sched;

  localparam int FLOWS = 2;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int TW    = 10;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic [N-1:0]    SU_DVLD;
  logic [N*DW-1:0] SU_DATA;
  logic [N-1:0]    SU_INTF;
  logic [N-1:0]    SU_LFF;
  logic [TW-1:0]   TIMEOUT;
  logic            ENABLE;
  logic            DMA_REQ;
  logic [63:0]     DMA_ADDR;
  logic [DW-1:0]   DMA_DATA;
  logic            DMA_ACK;
  logic            DMA_DONE;
  logic [N-1:0]    INTERRUPT;
  logic            BUSY;

  always #5 CLK = ~CLK;

  sum_update_sched #(
    .FLOWS         (FLOWS),
    .SU_DATA_WIDTH (DW),
    .BASE_ADDR     (64'h0),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .SU_DVLD   (SU_DVLD),
    .SU_DATA   (SU_DATA),
    .SU_INTF   (SU_INTF),
    .SU_LFF    (SU_LFF),
    .TIMEOUT   (TIMEOUT),
    .ENABLE    (ENABLE),
    .DMA_REQ   (DMA_REQ),
    .DMA_ADDR  (DMA_ADDR),
    .DMA_DATA  (DMA_DATA),
    .DMA_ACK   (DMA_ACK),
    .DMA_DONE  (DMA_DONE),
    .INTERRUPT (INTERRUPT),
    .BUSY      (BUSY)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [95:0] exp_wr [$];
  logic [3:0]  exp_int [$];
  int          ack_delay  = 0;
  int          done_delay = 0;
  bit          same_cycle = 1'b0;
  logic [127:0] d4;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_unexp(input string name, input logic [95:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] slot(input int idx, input logic [31:0] d);
    return 128'(d) << (32 * idx);
  endfunction

  function automatic logic [95:0] wr(input int idx, input logic [31:0] d);
    return {64'(8 * idx), d};
  endfunction

  task automatic pulse_su(input logic [3:0] m, input logic [127:0] d,
                          input logic [3:0] fi, input logic [3:0] fl);
    SU_DVLD = m;
    SU_DATA = d;
    SU_INTF = fi;
    SU_LFF  = fl;
    step();
    SU_DVLD = '0;
    SU_INTF = '0;
    SU_LFF  = '0;
  endtask

  // Cycles from the update strobe to the first visible DMA_REQ.
  task automatic req_latency(input string name, input int exp_lat);
    int cnt;
    cnt = 1;
    while (!DMA_REQ && cnt < 200) begin
      step();
      cnt++;
    end
    check(name, 96'(cnt), 96'(exp_lat));
  endtask

  task automatic wait_req(input string name, input logic level);
    int k;
    k = 0;
    while (DMA_REQ !== level && k < 500) begin
      step();
      k++;
    end
    if (k >= 500) fail_unexp(name, 96'(k));
  endtask

  task automatic wait_quiet(input string name);
    int k;
    k = 0;
    while ((exp_wr.size() != 0 || exp_int.size() != 0 || BUSY) && k < 2000) begin
      step();
      k++;
    end
    if (k >= 2000) fail_unexp(name, 96'(exp_wr.size()));
    repeat (3) step();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or interrupt.
  logic        in_req = 1'b0;
  logic        both_seen = 1'b0;
  logic [95:0] cur_wr = '0;
  initial begin
    forever begin
      @(negedge CLK);
      if (DMA_REQ) begin
        if (!in_req) begin
          in_req = 1'b1;
          cur_wr = {DMA_ADDR, DMA_DATA};
          if (exp_wr.size() == 0) fail_unexp("unexpected_write", cur_wr);
          else check("write", cur_wr, exp_wr.pop_front());
        end else begin
          check("req_stable", {DMA_ADDR, DMA_DATA}, cur_wr);
        end
      end else begin
        in_req = 1'b0;
      end
      if (INTERRUPT != 4'b0000) begin
        if (exp_int.size() == 0) fail_unexp("unexpected_irq", 96'(INTERRUPT));
        else check("irq", 96'(INTERRUPT), 96'(exp_int.pop_front()));
      end
      if (both_seen) check("ackdone_idle", {94'b0, BUSY, DMA_REQ}, 96'd0);
      both_seen = DMA_REQ && DMA_ACK && DMA_DONE;
    end
  end

  // DMA responder with programmable ACK/DONE timing.
  initial begin
    DMA_ACK  = 1'b0;
    DMA_DONE = 1'b0;
    forever begin
      step();
      if (DMA_REQ && RESET_N) begin
        repeat (ack_delay) step();
        DMA_ACK  = 1'b1;
        DMA_DONE = same_cycle;
        step();
        DMA_ACK  = 1'b0;
        DMA_DONE = 1'b0;
        if (!same_cycle) begin
          repeat (done_delay) step();
          DMA_DONE = 1'b1;
          step();
          DMA_DONE = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET_N = 1'b0;
    ENABLE  = 1'b0;
    SU_DVLD = '0;
    SU_DATA = '0;
    SU_INTF = '0;
    SU_LFF  = '0;
    TIMEOUT = 10'd100;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_req",  96'(DMA_REQ),   96'd0);
    check("rst_addr", 96'(DMA_ADDR),  96'd0);
    check("rst_data", 96'(DMA_DATA),  96'd0);
    check("rst_irq",  96'(INTERRUPT), 96'd0);
    check("rst_busy", 96'(BUSY),      96'd0);
    RESET_N = 1'b1;
    step();
    ENABLE = 1'b1;

    // Single update with INTF
    exp_wr.push_back(wr(1, 32'hA5A5_0001));
    exp_int.push_back(4'b0010);
    pulse_su(4'b0010, slot(1, 32'hA5A5_0001), 4'b0010, 4'b0000);
    req_latency("t1_latency", 2);
    wait_quiet("t1_quiet");

    // Timeout flush, no flags
    TIMEOUT = 10'd20;
    exp_wr.push_back(wr(2, 32'h0000_2222));
    pulse_su(4'b0100, slot(2, 32'h0000_2222), 4'b0000, 4'b0000);
    req_latency("t2_latency", 22);
    wait_quiet("t2_quiet");

    // Zero timeout: eligible the cycle after capture
    TIMEOUT = 10'd0;
    exp_wr.push_back(wr(0, 32'h0000_0777));
    pulse_su(4'b0001, slot(0, 32'h0000_0777), 4'b0000, 4'b0000);
    req_latency("t0_latency", 2);
    wait_quiet("t0_quiet");
    TIMEOUT = 10'd100;

    // Coalescing while disabled
    ENABLE = 1'b0;
    pulse_su(4'b0001, slot(0, 32'h1), 4'b0000, 4'b0000);
    pulse_su(4'b0001, slot(0, 32'h2), 4'b0001, 4'b0000);
    pulse_su(4'b0001, slot(0, 32'h3), 4'b0000, 4'b0000);
    repeat (5) step();
    check("t3_no_req_disabled", 96'(DMA_REQ), 96'd0);
    exp_wr.push_back(wr(0, 32'h3));
    exp_int.push_back(4'b0001);
    ENABLE = 1'b1;
    wait_quiet("t3_quiet");

    // Requester 3 via LFF brings the pointer back to 0
    exp_wr.push_back(wr(3, 32'h3000_0003));
    pulse_su(4'b1000, slot(3, 32'h3000_0003), 4'b0000, 4'b1000);
    wait_quiet("ptr_quiet");

    // Fairness: all four eligible, twice
    for (int r = 0; r < 2; r++) begin
      ENABLE = 1'b0;
      for (int i = 0; i < N; i++) begin
        d4[i*32 +: 32] = 32'h4000_0000 | (32'(r) << 8) | 32'(i);
        exp_wr.push_back(wr(i, d4[i*32 +: 32]));
      end
      exp_int.push_back(4'b0010);
      exp_int.push_back(4'b0100);
      pulse_su(4'b1111, d4, 4'b0110, 4'b1111);
      step();
      ENABLE = 1'b1;
      wait_quiet("t4_quiet");
    end

    // Same-cycle ACK and DONE
    same_cycle = 1'b1;
    exp_wr.push_back(wr(1, 32'h5555_AAAA));
    exp_int.push_back(4'b0010);
    pulse_su(4'b0010, slot(1, 32'h5555_AAAA), 4'b0010, 4'b0000);
    wait_quiet("t5a_quiet");
    same_cycle = 1'b0;

    // ACK delayed 50 cycles: request fields must hold
    ack_delay = 50;
    exp_wr.push_back(wr(2, 32'hDEAD_BEEF));
    pulse_su(4'b0100, slot(2, 32'hDEAD_BEEF), 4'b0000, 4'b0100);
    wait_quiet("t5b_quiet");
    ack_delay = 0;

    // Reset during WAIT_DONE with two entries still pending
    done_delay = 30;
    exp_wr.push_back(wr(3, 32'h3333_0000));
    pulse_su(4'b1011, slot(3, 32'h3333_0000) | slot(0, 32'h0000_1111) | slot(1, 32'h0000_2222),
             4'b1011, 4'b0000);
    wait_req("t6_req_up", 1'b1);
    wait_req("t6_req_down", 1'b0);
    repeat (3) step();
    check("t6_busy_wait_done", 96'(BUSY), 96'd1);
    RESET_N = 1'b0;
    #1;
    check("t6_rst_req",  96'(DMA_REQ),   96'd0);
    check("t6_rst_addr", 96'(DMA_ADDR),  96'd0);
    check("t6_rst_data", 96'(DMA_DATA),  96'd0);
    check("t6_rst_irq",  96'(INTERRUPT), 96'd0);
    check("t6_rst_busy", 96'(BUSY),      96'd0);
    repeat (2) step();
    RESET_N = 1'b1;
    repeat (80) step();
    check("t6_no_req",  96'(DMA_REQ), 96'd0);
    check("t6_no_busy", 96'(BUSY),    96'd0);
    done_delay = 0;

    check("sb_writes_left", 96'(exp_wr.size()),  96'd0);
    check("sb_irqs_left",   96'(exp_int.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
